// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction loader.
//   ld_state_t : loader FSM encoding (2 bits)
//   INSTR_W    : instruction word width
//   NOP_INSTR  : word returned for unloaded or out-of-range addresses
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LO   = 2'd1,
    LD_HI   = 2'd2,
    LD_RUN  = 2'd3
  } ld_state_t;

endpackage

// File: rtl/instruction_loader_if.sv
// Bus between the program source / program counter side and the loader.
//   start_load, end_load : single-cycle control pulses
//   byte_in, byte_valid  : program byte stream, at most one byte per cycle
//   pc_addr, instr_out   : instruction fetch, registered read (1 cycle)
//   cpu_hold, prog_len, overflow : loader status
//   state                : FSM state, exposed for debug/checkers
// Handshake: byte_valid is a qualifier with no back-pressure. A byte is
// consumed in the cycle byte_valid is high; the loader never stalls the
// source, it drops the byte when memory is full or a restart coincides.
interface instruction_loader_if
  import cpu_pkg::*;
#(parameter int DEPTH = 32);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                start_load;
  logic                end_load;
  logic [7:0]          byte_in;
  logic                byte_valid;
  logic [ADDR_W-1:0]   pc_addr;
  logic [INSTR_W-1:0]  instr_out;
  logic                cpu_hold;
  logic [ADDR_W:0]     prog_len;
  logic                overflow;
  ld_state_t           state;

  modport master (
    output start_load, end_load, byte_in, byte_valid, pc_addr,
    input  instr_out, cpu_hold, prog_len, overflow, state
  );

  modport slave (
    input  start_load, end_load, byte_in, byte_valid, pc_addr,
    output instr_out, cpu_hold, prog_len, overflow, state
  );
endinterface

// File: rtl/loader_mem.sv
// DEPTH x 16 instruction register file.
//   clk, rst : clock, synchronous active-high reset (read register only)
//   we, waddr, wdata : synchronous write port
//   raddr, rd_en     : read address and gate; gated reads return NOP
//   rdata            : registered read data
// The array itself is not reset; stale words are hidden by rd_en.
module loader_mem
  import cpu_pkg::*;
#(parameter int DEPTH = 32)
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [$clog2(DEPTH)-1:0]  waddr,
  input  logic [INSTR_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0]  raddr,
  input  logic                      rd_en,
  output logic [INSTR_W-1:0]        rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)        rdata <= NOP_INSTR;
    else if (rd_en) rdata <= mem[raddr];
    else            rdata <= NOP_INSTR;
  end

endmodule

// File: rtl/instruction_loader.sv
// Loads a little-endian byte stream into instruction memory, holds the CPU
// in reset while loading, then serves instruction words to the PC stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : instruction_loader_if slave (controls, byte stream, fetch,
//              status and debug state)
module instruction_loader
  import cpu_pkg::*;
#(parameter int DEPTH = 32)
(
  input  logic                 clk,
  input  logic                 rst,
  instruction_loader_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W+1)'(DEPTH);

  ld_state_t          state, state_n;
  logic [ADDR_W-1:0]  wptr, wptr_n;
  logic [ADDR_W:0]    prog_len, len_n;
  logic [7:0]         lo_byte, lo_n;
  logic               overflow, ovf_n;
  logic               cpu_hold;
  logic               we;
  logic [INSTR_W-1:0] wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LD_IDLE;
      wptr     <= '0;
      prog_len <= '0;
      lo_byte  <= '0;
      overflow <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      state    <= state_n;
      wptr     <= wptr_n;
      prog_len <= len_n;
      lo_byte  <= lo_n;
      overflow <= ovf_n;
      // Decoded from the next state so hold tracks the state register exactly.
      cpu_hold <= (state_n != LD_RUN);
    end
  end

  always_comb begin
    state_n = state;
    wptr_n  = wptr;
    len_n   = prog_len;
    lo_n    = lo_byte;
    ovf_n   = overflow;
    we      = 1'b0;
    wdata   = {8'h00, lo_byte};

    if (bus.start_load) begin
      // Restart from any state; a coinciding byte and any half word are lost.
      state_n = LD_LO;
      wptr_n  = '0;
      len_n   = '0;
      ovf_n   = 1'b0;
    end else begin
      unique case (state)
        LD_IDLE: ;
        LD_LO: begin
          if (bus.byte_valid) begin
            if (prog_len < FULL_LEN) begin
              lo_n    = bus.byte_in;
              state_n = LD_HI;
            end else begin
              ovf_n = 1'b1;
            end
          end
          if (bus.end_load) state_n = LD_RUN;
        end
        LD_HI: begin
          // Only reachable with prog_len < DEPTH, so no full check here.
          if (bus.byte_valid) begin
            we      = 1'b1;
            wdata   = {bus.byte_in, lo_byte};
            wptr_n  = wptr + 1'b1;
            len_n   = prog_len + 1'b1;
            state_n = bus.end_load ? LD_RUN : LD_LO;
          end else if (bus.end_load) begin
            // Trailing odd byte is kept as a zero-extended word.
            we      = 1'b1;
            len_n   = prog_len + 1'b1;
            state_n = LD_RUN;
          end
        end
        LD_RUN: ;
        default: state_n = LD_IDLE;
      endcase
    end
  end

  loader_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wptr),
    .wdata (wdata),
    .raddr (bus.pc_addr),
    .rd_en ({1'b0, bus.pc_addr} < prog_len),
    .rdata (bus.instr_out)
  );

  assign bus.cpu_hold = cpu_hold;
  assign bus.prog_len = prog_len;
  assign bus.overflow = overflow;
  assign bus.state    = state;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: directed scenarios followed by random loads,
// checked against a byte-list model of the loaded program.
module tb_instruction_loader;
  import cpu_pkg::*;

  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  // Model: bytes accepted since the last start_load, and the words they form.
  logic [7:0]  bq[$];
  logic [15:0] exp_q[$];

  instruction_loader_if #(.DEPTH(DEPTH)) bus();

  instruction_loader #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_len();
    int w;
    w = (bq.size() + 1) / 2;
    return (w > DEPTH) ? DEPTH : w;
  endfunction

  task automatic build_words();
    exp_q.delete();
    for (int a = 0; a < exp_len(); a++) begin
      logic [7:0] hi;
      hi = (2*a + 1 < bq.size()) ? bq[2*a+1] : 8'h00;
      exp_q.push_back({hi, bq[2*a]});
    end
  endtask

  function automatic logic [15:0] exp_word(input int a);
    return (a < exp_q.size()) ? exp_q[a] : NOP_INSTR;
  endfunction

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    bus.start_load = 1'b0;
    bus.end_load   = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
  endtask

  task automatic do_start();
    bus.start_load = 1'b1;
    step();
    bus.start_load = 1'b0;
    bq.delete();
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    step();
    bus.byte_valid = 1'b0;
    bq.push_back(b);
  endtask

  task automatic do_end(input string tag);
    bus.end_load = 1'b1;
    step();
    bus.end_load = 1'b0;
    build_words();
    chk({tag, "_hold"}, 32'(bus.cpu_hold), 32'd0);
    chk({tag, "_len"}, 32'(bus.prog_len), 32'(exp_len()));
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'(bq.size() > 2*DEPTH));
  endtask

  task automatic check_read(input string tag, input int a);
    bus.pc_addr = a[4:0];
    step();
    chk(tag, 32'(bus.instr_out), 32'(exp_word(a)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    bus.pc_addr = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_instr", 32'(bus.instr_out), 32'h0000);
    chk("rst_hold",  32'(bus.cpu_hold),  32'd1);
    chk("rst_len",   32'(bus.prog_len),  32'd0);
    chk("rst_ovf",   32'(bus.overflow),  32'd0);
    chk("rst_state", 32'(bus.state),     32'(LD_IDLE));

    // Two full words
    do_start();
    chk("load_hold", 32'(bus.cpu_hold), 32'd1);
    send_byte(8'h34); send_byte(8'h12); send_byte(8'h78); send_byte(8'h56);
    do_end("two");
    check_read("two_rd0", 0);
    chk("two_rd0_val", 32'(bus.instr_out), 32'h1234);
    check_read("two_rd1", 1);
    chk("two_rd1_val", 32'(bus.instr_out), 32'h5678);
    check_read("two_rd2", 2);

    // Odd byte count: trailing byte zero-extended
    do_start();
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF);
    do_end("odd");
    check_read("odd_rd1", 1);
    chk("odd_rd1_val", 32'(bus.instr_out), 32'h00EF);
    check_read("odd_rd0", 0);

    // Full memory plus one extra byte
    do_start();
    for (int i = 0; i < 2*DEPTH; i++) send_byte((i % 2 == 0) ? 8'(i/2) : 8'h00);
    send_byte(8'h99);
    do_end("full");
    chk("full_len_val", 32'(bus.prog_len), 32'd32);
    chk("full_ovf_val", 32'(bus.overflow), 32'd1);
    check_read("full_rd31", 31);
    chk("full_rd31_val", 32'(bus.instr_out), 32'h001F);
    check_read("full_rd0", 0);

    // start_load in RUN with a coinciding byte: byte dropped, restart
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'h55;
    do_start();
    bus.byte_valid = 1'b0;
    chk("rs_hold",  32'(bus.cpu_hold), 32'd1);
    chk("rs_len",   32'(bus.prog_len), 32'd0);
    chk("rs_ovf",   32'(bus.overflow), 32'd0);
    chk("rs_state", 32'(bus.state),    32'(LD_LO));
    check_read("rs_rd0", 0);
    do_end("rs_empty");

    // end_load together with the high byte
    do_start();
    send_byte(8'h01);
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'h02;
    bq.push_back(8'h02);
    do_end("endhi");
    bus.byte_valid = 1'b0;
    check_read("endhi_rd0", 0);
    chk("endhi_rd0_val", 32'(bus.instr_out), 32'h0201);

    // Restart mid-load loses the half word
    do_start();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    do_start();
    send_byte(8'h44); send_byte(8'h55);
    do_end("restart");
    check_read("restart_rd0", 0);
    chk("restart_rd0_val", 32'(bus.instr_out), 32'h5544);
    check_read("restart_rd1", 1);

    // Reset mid-load
    do_start();
    send_byte(8'hA1); send_byte(8'hA2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bq.delete();
    exp_q.delete();
    chk("mrst_state", 32'(bus.state),    32'(LD_IDLE));
    chk("mrst_len",   32'(bus.prog_len), 32'd0);
    chk("mrst_hold",  32'(bus.cpu_hold), 32'd1);
    check_read("mrst_rd0", 0);
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'h77;
    step();
    bus.byte_valid = 1'b0;
    chk("idle_byte_state", 32'(bus.state),    32'(LD_IDLE));
    chk("idle_byte_len",   32'(bus.prog_len), 32'd0);

    // Random loads
    for (int it = 0; it < 8; it++) begin
      int n;
      do_start();
      n = $urandom_range(0, 70);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) step();
        send_byte(8'($urandom));
      end
      do_end($sformatf("rnd%0d", it));
      for (int k = 0; k < 10; k++)
        check_read($sformatf("rnd%0d_rd", it), $urandom_range(0, DEPTH-1));
      if (exp_len() > 0) check_read($sformatf("rnd%0d_last", it), exp_len() - 1);
      if (exp_len() < DEPTH) check_read($sformatf("rnd%0d_past", it), exp_len());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
